// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war match controller.
package tug_pkg;
  typedef enum logic [1:0] {PLAY = 2'd0, POINT = 2'd1, OVER = 2'd2} tug_state_e;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_L     = 2'b10;
  localparam logic [1:0] WIN_R     = 2'b01;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/tug_match_ctrl_if.sv
// Player inputs, light-chain controls and score/display outputs of the match controller.
interface tug_match_ctrl_if;
  logic       l_press, r_press;
  logic       l_edge_on, r_edge_on;
  logic [8:0] cpu_thresh;
  logic       l_move, r_move;
  logic       field_reset;
  logic [3:0] l_score, r_score;
  logic [1:0] winner;
  logic [6:0] l_hex, r_hex;

  modport master (
    output l_press, r_press, l_edge_on, r_edge_on, cpu_thresh,
    input  l_move, r_move, field_reset, l_score, r_score, winner, l_hex, r_hex
  );
  modport slave (
    input  l_press, r_press, l_edge_on, r_edge_on, cpu_thresh,
    output l_move, r_move, field_reset, l_score, r_score, winner, l_hex, r_hex
  );
endinterface

// File: rtl/tug_match_ctrl_seg7.sv
// Score digit decoder: active-low segments {g,f,e,d,c,b,a}; values above 9 are blanked.
module score_seg7
  import tug_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_val)
      4'd0: o_seg = 7'h40;
      4'd1: o_seg = 7'h79;
      4'd2: o_seg = 7'h24;
      4'd3: o_seg = 7'h30;
      4'd4: o_seg = 7'h19;
      4'd5: o_seg = 7'h12;
      4'd6: o_seg = 7'h02;
      4'd7: o_seg = 7'h78;
      4'd8: o_seg = 7'h00;
      4'd9: o_seg = 7'h10;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/tug_match_ctrl.sv
// Tug-of-war match FSM: gates moves, scores edge hits, pauses the field, declares a winner.
// Define CPU_PLAYER_EN to replace the right-hand button with an LFSR-driven CPU player.
module tug_match_ctrl
  import tug_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  tug_match_ctrl_if.slave bus
);
  localparam int CW = $clog2(PAUSE_CYCLES + 1);

  tug_state_e    r_state;
  logic [3:0]    r_l_score, r_r_score;
  logic [1:0]    r_winner;
  logic [CW-1:0] r_cnt;
  logic          r_l_move, r_r_move, r_rst_pulse, r_scorer_r;

  logic          w_l_eff, w_r_eff, w_in_play, w_l_only, w_r_only;
  logic          w_l_win, w_r_win, w_pause_done;
  logic [3:0]    w_scorer_cnt;

`ifdef CPU_PLAYER_EN
  logic [9:0] r_lfsr;
  logic       w_unused_rpress;

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= 10'h001;
    else       r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
  end
  assign w_r_eff         = (r_lfsr[8:0] < bus.cpu_thresh);
  assign w_unused_rpress = bus.r_press;
`else
  logic w_unused_thresh;
  assign w_r_eff         = bus.r_press;
  assign w_unused_thresh = ^bus.cpu_thresh;
`endif

  // Simultaneous presses cancel, so a scoring press never coincides with a move.
  assign w_l_eff      = bus.l_press;
  assign w_in_play    = (r_state == PLAY);
  assign w_l_only     = w_in_play & w_l_eff & ~w_r_eff;
  assign w_r_only     = w_in_play & w_r_eff & ~w_l_eff;
  assign w_l_win      = w_l_only & bus.l_edge_on;
  assign w_r_win      = w_r_only & bus.r_edge_on;
  assign w_pause_done = (r_cnt == CW'(PAUSE_CYCLES - 1));
  assign w_scorer_cnt = r_scorer_r ? r_r_score : r_l_score;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= PLAY;
      r_l_score   <= '0;
      r_r_score   <= '0;
      r_winner    <= WIN_NONE;
      r_cnt       <= '0;
      r_l_move    <= 1'b0;
      r_r_move    <= 1'b0;
      r_scorer_r  <= 1'b0;
      r_rst_pulse <= 1'b1;
    end else begin
      r_rst_pulse <= 1'b0;
      r_l_move    <= w_l_only & ~bus.l_edge_on;
      r_r_move    <= w_r_only & ~bus.r_edge_on;
      case (r_state)
        PLAY: begin
          if (w_l_win || w_r_win) begin
            r_state    <= POINT;
            r_cnt      <= '0;
            r_scorer_r <= w_r_win;
            if (w_l_win && r_l_score < 4'(WIN_SCORE)) r_l_score <= r_l_score + 4'd1;
            if (w_r_win && r_r_score < 4'(WIN_SCORE)) r_r_score <= r_r_score + 4'd1;
          end
        end
        POINT: begin
          if (w_pause_done) begin
            if (w_scorer_cnt == 4'(WIN_SCORE)) begin
              r_state  <= OVER;
              r_winner <= r_scorer_r ? WIN_R : WIN_L;
            end else begin
              r_state <= PLAY;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;  // OVER is terminal until reset
      endcase
    end
  end

  assign bus.l_move      = r_l_move;
  assign bus.r_move      = r_r_move;
  assign bus.field_reset = r_rst_pulse | (r_state == POINT);
  assign bus.l_score     = r_l_score;
  assign bus.r_score     = r_r_score;
  assign bus.winner      = r_winner;

  score_seg7 u_l_seg (.i_val(r_l_score), .o_seg(bus.l_hex));
  score_seg7 u_r_seg (.i_val(r_r_score), .o_seg(bus.r_hex));
endmodule

// File: tb/tb_tug_match_ctrl.sv
// Scoreboard bench for tug_match_ctrl: directed vectors push expected outputs, a negedge monitor checks.
module tb_tug_match_ctrl;
  import tug_pkg::*;

  typedef struct {
    bit         lm, rm, fr;
    int         ls, rs;
    logic [1:0] win;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  bit [9:0] ref_lfsr = 10'h001;

  tug_match_ctrl_if bus();

  tug_match_ctrl #(.WIN_SCORE(7), .PAUSE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("l_move",      32'(bus.l_move),      32'(e.lm));
      chk("r_move",      32'(bus.r_move),      32'(e.rm));
      chk("field_reset", 32'(bus.field_reset), 32'(e.fr));
      chk("l_score",     32'(bus.l_score),     32'(e.ls));
      chk("r_score",     32'(bus.r_score),     32'(e.rs));
      chk("winner",      32'(bus.winner),      32'(e.win));
      chk("l_hex",       32'(bus.l_hex),       32'(seg(e.ls)));
      chk("r_hex",       32'(bus.r_hex),       32'(seg(e.rs)));
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic go(input bit rst, l, r, le, re, input bit lm, rm, fr,
                    input int ls, rs, input logic [1:0] win);
    exp_t e;
    reset         = rst;
    bus.l_press   = l;
    bus.r_press   = r;
    bus.l_edge_on = le;
    bus.r_edge_on = re;
    e.lm = lm; e.rm = rm; e.fr = fr; e.ls = ls; e.rs = rs; e.win = win;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) ref_lfsr = 10'h001;
    else     ref_lfsr = {ref_lfsr[8:0], ref_lfsr[9] ^ ref_lfsr[6]};
  endtask

  initial begin
    bus.cpu_thresh = 9'h000;
    go(1, 0,0,0,0, 0,0,1, 0,0,WIN_NONE);
    go(1, 0,0,0,0, 0,0,1, 0,0,WIN_NONE);
    go(0, 0,0,0,0, 0,0,0, 0,0,WIN_NONE);
`ifndef CPU_PLAYER_EN
    // non-winning presses become one-cycle moves
    go(0, 1,0,0,0, 1,0,0, 0,0,WIN_NONE);
    go(0, 0,0,0,0, 0,0,0, 0,0,WIN_NONE);
    go(0, 0,1,0,0, 0,1,0, 0,0,WIN_NONE);
    go(0, 0,0,0,0, 0,0,0, 0,0,WIN_NONE);
    // simultaneous presses cancel, even with both edge lights on
    go(0, 1,1,0,0, 0,0,0, 0,0,WIN_NONE);
    go(0, 1,1,1,1, 0,0,0, 0,0,WIN_NONE);
    go(0, 0,0,0,0, 0,0,0, 0,0,WIN_NONE);
    // right point: four-cycle pause, presses ignored, then play resumes
    go(0, 0,1,0,1, 0,0,1, 0,1,WIN_NONE);
    go(0, 1,0,1,0, 0,0,1, 0,1,WIN_NONE);
    go(0, 0,1,0,1, 0,0,1, 0,1,WIN_NONE);
    go(0, 1,0,0,0, 0,0,1, 0,1,WIN_NONE);
    go(0, 0,0,0,0, 0,0,0, 0,1,WIN_NONE);
    go(0, 1,0,0,0, 1,0,0, 0,1,WIN_NONE);
    // reset in the second pause cycle aborts the point
    go(0, 1,0,1,0, 0,0,1, 1,1,WIN_NONE);
    go(0, 0,0,0,0, 0,0,1, 1,1,WIN_NONE);
    go(1, 0,0,0,0, 0,0,1, 0,0,WIN_NONE);
    go(0, 0,0,0,0, 0,0,0, 0,0,WIN_NONE);
    go(0, 1,0,0,0, 1,0,0, 0,0,WIN_NONE);
    // seven left points win the match
    for (int i = 1; i <= 7; i++) begin
      go(0, 1,0,1,0, 0,0,1, i,0,WIN_NONE);
      repeat (3) go(0, 0,0,0,0, 0,0,1, i,0,WIN_NONE);
      go(0, 0,0,0,0, 0,0,0, i,0, (i == 7) ? WIN_L : WIN_NONE);
    end
    // match over: everything frozen
    go(0, 1,0,0,0, 0,0,0, 7,0,WIN_L);
    go(0, 0,1,0,1, 0,0,0, 7,0,WIN_L);
    go(0, 1,0,1,0, 0,0,0, 7,0,WIN_L);
    go(0, 0,1,0,0, 0,0,0, 7,0,WIN_L);
    go(1, 0,0,0,0, 0,0,1, 0,0,WIN_NONE);
    go(0, 0,0,0,0, 0,0,0, 0,0,WIN_NONE);
`else
    // CPU never presses at threshold 0; the physical right button is ignored
    go(1, 0,0,0,0, 0,0,1, 0,0,WIN_NONE);
    repeat (1000) go(0, 0,1,0,0, 0,0,0, 0,0,WIN_NONE);
    bus.cpu_thresh = 9'h1FF;
    for (int i = 0; i < 300; i++) begin
      bit erm;
      erm = (ref_lfsr[8:0] != 9'h1FF);
      go(0, 0,0,0,0, 0,erm,0, 0,0,WIN_NONE);
    end
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tug_match_ctrl.md
TUG_MATCH_CTRL -- requirements
Module: tug_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win a match (range 1..9).
REQ-002 Parameter PAUSE_CYCLES, default 4, number of cycles the playfield is held in reset after a point (minimum 1).
REQ-003 clk  input  1  system clock; every flop uses the rising edge.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 l_press, r_press  input  1 each  single-cycle press pulses from the edge-detected player buttons.
REQ-006 l_edge_on, r_edge_on  input  1 each  leftmost and rightmost playfield lights are lit.
REQ-007 cpu_thresh  input  9  CPU opponent press threshold; used only when CPU_PLAYER_EN is defined.
REQ-008 l_move, r_move  output  1 each  gated move pulses to the light chain.
REQ-009 field_reset  output  1  reset for the light chain.
REQ-010 l_score, r_score  output  4 each  binary point counts.
REQ-011 winner  output  2  match result: 00 none, 10 left, 01 right.
REQ-012 l_hex, r_hex  output  7 each  active-low 7-segment digits for the scores.

Function
REQ-013 The FSM SHALL have three states: PLAY, POINT, OVER.
REQ-014 PLAY, effective press by exactly one player, that player's edge light on: the press is a winning press.
  - The scorer's count increments by 1.
  - The press is not forwarded as a move.
  - Next state is POINT.
REQ-015 PLAY, non-winning press by exactly one player: the matching move output is asserted for exactly one cycle, one cycle after the press (registered, latency 1).
REQ-016 PLAY, both effective presses in the same cycle: both are cancelled; no move, no score change.
REQ-017 POINT behaviour:
  - field_reset is held high for exactly PAUSE_CYCLES cycles.
  - All presses are ignored.
  - On exit, next state is OVER if the scorer's count equals WIN_SCORE, otherwise PLAY.
REQ-018 The pause counter is $clog2(PAUSE_CYCLES+1) bits, loads 0 on entry to POINT, and does not wrap.
REQ-019 OVER behaviour:
  - winner is set to the scorer's code.
  - field_reset is low and both move outputs are low.
  - Scores are frozen.
  - The block stays in OVER until reset.
REQ-020 Score counts never exceed WIN_SCORE; no wrap-around.
REQ-021 l_hex and r_hex are a combinational decode of the scores: digits 0-9 shown, blank (7'h7F) for values above 9.
REQ-022 Presses arriving in the same cycle as the PLAY-to-POINT transition are dropped; no move is queued.

Reset
REQ-023 On reset, the block SHALL enter this state on the next clock edge, from any state, including mid-POINT:
  - state PLAY
  - scores 0
  - winner 00
  - pause counter 0
  - l_move and r_move 0
  - field_reset 1 for that cycle, then 0
REQ-024 The digit outputs SHALL show 0 (7'h40) the cycle after reset is asserted.

Configuration
REQ-025 Macro CPU_PLAYER_EN, when defined, SHALL implement a CPU right-hand player:
  - r_press is ignored.
  - A 10-bit Fibonacci LFSR (taps 10,7; seeded 10'h001 on reset) advances every cycle.
  - The effective right press is (lfsr[8:0] < cpu_thresh).
  - cpu_thresh = 0 means the CPU never presses.
REQ-026 When CPU_PLAYER_EN is not defined:
  - The effective right press is r_press.
  - cpu_thresh is unused.
  - No LFSR is synthesised.

Structure
REQ-027 Shared package tug_pkg SHALL hold:
  - the state enum (PLAY, POINT, OVER)
  - the winner codes (WIN_NONE, WIN_L, WIN_R)
  - the blank-digit constant
REQ-028 Sub-module score_seg7 (4-bit in, 7-bit active-low out) SHALL be instantiated twice.

Verification
REQ-029 Reset pulse; then l_press with l_edge_on=0 → l_move high exactly one cycle later, for one cycle; scores stay 0.
REQ-030 l_press and r_press in the same cycle → no move pulse, scores unchanged, state stays PLAY.
REQ-031 r_edge_on=1 plus r_press → r_score goes 0→1, r_move stays low, field_reset high for 4 cycles, then back to PLAY; presses during the pause are ignored.
REQ-032 Seven left winning presses (WIN_SCORE=7) → l_score=7, winner=10, l_hex=7'h78; later presses produce no moves and no score change.
REQ-033 Reset asserted in the 2nd cycle of POINT → next cycle shows scores 0, state PLAY, winner 00, pause aborted.
REQ-034 With CPU_PLAYER_EN defined:
  - cpu_thresh=0 → no right moves over 1000 cycles.
  - cpu_thresh=9'h1FF → a right move every cycle in which lfsr[8:0]≠9'h1FF, matching a reference LFSR model.
